// File: rtl/temp_result_filter_if.sv
// Raw conversion-result stream from the temperature sensor into the result filter.
interface temp_result_filter_if #(
  parameter int N_RES = 6
);
  logic             i_res_valid;
  logic [N_RES-1:0] i_res;

  modport master (output i_res_valid, output i_res);
  modport slave  (input  i_res_valid, input  i_res);
endinterface

// File: rtl/temp_result_filter.sv
// Rounded block averager with min/max tracking and hysteresis over-temperature alarm.
// Optional spike rejection is enabled by defining TEMP_FILTER_SPIKE_REJECT_EN.
//
// state | meaning
// FILL  | no average produced since reset
// RUN   | at least one block average has been produced
module temp_result_filter #(
  parameter int N_RES    = 6,
  parameter int LOG2_AVG = 2,
  parameter int MAX_STEP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  temp_result_filter_if.slave  res_bus,
  input  logic                 i_clear_minmax,
  input  logic [N_RES-1:0]     i_thr_hi,
  input  logic [N_RES-1:0]     i_thr_lo,
  output logic [N_RES-1:0]     o_avg,
  output logic                 o_avg_valid,
  output logic                 o_have_avg,
  output logic [N_RES-1:0]     o_min,
  output logic [N_RES-1:0]     o_max,
  output logic                 o_alarm,
  output logic [3:0]           o_reject_cnt
);

  localparam int AW = N_RES + LOG2_AVG + 1;
  localparam logic [AW-1:0] ROUND = AW'(1) << (LOG2_AVG - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t              state;
  logic [AW-1:0]       acc;
  logic [LOG2_AVG-1:0] cnt;

  logic                accept;
  logic                block_done;
  logic [AW-1:0]       acc_add;
  logic [AW-1:0]       rounded;
  logic [N_RES-1:0]    new_avg;
  logic                unused_round_bits;

  assign acc_add    = acc + {{(LOG2_AVG + 1){1'b0}}, res_bus.i_res};
  assign rounded    = acc_add + ROUND;
  assign new_avg    = rounded[LOG2_AVG +: N_RES];
  assign block_done = accept && (cnt == '1);
  // the sum never exceeds (2**N_RES-1) after the shift, so the top bit is always zero
  assign unused_round_bits = ^{rounded[AW-1], rounded[LOG2_AVG-1:0]};

`ifdef TEMP_FILTER_SPIKE_REJECT_EN
  localparam logic [N_RES:0] MAX_STEP_W = (N_RES + 1)'(MAX_STEP);

  logic [N_RES-1:0] last_s;
  logic             have_ref;
  logic [1:0]       rej_run;
  logic [3:0]       rej_cnt;
  logic [N_RES-1:0] diff;
  logic             spike;
  logic             force_acc;
  logic             reject;

  always_comb begin
    diff = '0;
    if (res_bus.i_res > last_s) diff = res_bus.i_res - last_s;
    else                        diff = last_s - res_bus.i_res;
  end

  assign spike     = have_ref && ({1'b0, diff} > MAX_STEP_W);
  // a third out-of-range sample in a row is treated as a real temperature step
  assign force_acc = spike && (rej_run == 2'd2);
  assign accept    = res_bus.i_res_valid && (!spike || force_acc);
  assign reject    = res_bus.i_res_valid && spike && !force_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_s   <= '0;
      have_ref <= 1'b0;
      rej_run  <= '0;
      rej_cnt  <= '0;
    end else if (accept) begin
      last_s   <= res_bus.i_res;
      have_ref <= 1'b1;
      rej_run  <= '0;
    end else if (reject) begin
      rej_run  <= rej_run + 2'd1;
      if (rej_cnt != 4'hF) rej_cnt <= rej_cnt + 4'd1;
    end
  end

  assign o_reject_cnt = rej_cnt;
`else
  logic unused_max_step;

  assign accept          = res_bus.i_res_valid;
  assign o_reject_cnt    = '0;
  assign unused_max_step = ^MAX_STEP;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      acc         <= '0;
      cnt         <= '0;
      o_avg       <= '0;
      o_avg_valid <= 1'b0;
      o_have_avg  <= 1'b0;
      o_min       <= '1;
      o_max       <= '0;
      o_alarm     <= 1'b0;
    end else begin
      o_avg_valid <= 1'b0;

      case (state)
        FILL: if (block_done) state <= RUN;
        RUN:  state <= RUN;
        default: state <= FILL;
      endcase

      if (accept) begin
        cnt <= cnt + 1'b1;
        if (block_done) begin
          acc         <= '0;
          o_avg       <= new_avg;
          o_avg_valid <= 1'b1;
          o_have_avg  <= 1'b1;
          // set wins when the thresholds overlap
          if (new_avg >= i_thr_hi)      o_alarm <= 1'b1;
          else if (new_avg <= i_thr_lo) o_alarm <= 1'b0;
        end else begin
          acc <= acc_add;
        end
      end

      if (i_clear_minmax && accept) begin
        o_min <= res_bus.i_res;
        o_max <= res_bus.i_res;
      end else if (i_clear_minmax) begin
        o_min <= '1;
        o_max <= '0;
      end else if (accept) begin
        if (res_bus.i_res < o_min) o_min <= res_bus.i_res;
        if (res_bus.i_res > o_max) o_max <= res_bus.i_res;
      end
    end
  end

endmodule

// File: tb/tb_temp_result_filter.sv
// Directed self-checking bench for temp_result_filter.
module tb_temp_result_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_clear_minmax;
  logic [5:0] i_thr_hi, i_thr_lo;
  logic [5:0] o_avg, o_min, o_max;
  logic       o_avg_valid, o_have_avg, o_alarm;
  logic [3:0] o_reject_cnt;

  int errors = 0;
  int checks = 0;

  temp_result_filter_if #(.N_RES(6)) bus ();

  temp_result_filter #(.N_RES(6), .LOG2_AVG(2), .MAX_STEP(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .res_bus        (bus),
    .i_clear_minmax (i_clear_minmax),
    .i_thr_hi       (i_thr_hi),
    .i_thr_lo       (i_thr_lo),
    .o_avg          (o_avg),
    .o_avg_valid    (o_avg_valid),
    .o_have_avg     (o_have_avg),
    .o_min          (o_min),
    .o_max          (o_max),
    .o_alarm        (o_alarm),
    .o_reject_cnt   (o_reject_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [5:0] v);
    @(negedge clk);
    bus.i_res_valid = 1'b1;
    bus.i_res       = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_res_valid = 1'b0;
      i_clear_minmax  = 1'b0;
    end
  endtask

  task automatic block4(input logic [5:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
    idle(1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_avg !== 6'd0)       begin errors++; $display("FAIL rst_avg got=%0d exp=0", o_avg); end
    checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL rst_avg_valid got=%0b exp=0", o_avg_valid); end
    checks++; if (o_have_avg !== 1'b0)  begin errors++; $display("FAIL rst_have_avg got=%0b exp=0", o_have_avg); end
    checks++; if (o_min !== 6'd63)      begin errors++; $display("FAIL rst_min got=%0d exp=63", o_min); end
    checks++; if (o_max !== 6'd0)       begin errors++; $display("FAIL rst_max got=%0d exp=0", o_max); end
    checks++; if (o_alarm !== 1'b0)     begin errors++; $display("FAIL rst_alarm got=%0b exp=0", o_alarm); end
    checks++; if (o_reject_cnt !== 4'd0) begin errors++; $display("FAIL rst_reject_cnt got=%0d exp=0", o_reject_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    send(10); send(11); send(12); send(13);
    checks++; if (o_have_avg !== 1'b0)  begin errors++; $display("FAIL b2b_early_have got=%0b exp=0", o_have_avg); end
    checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got=%0b exp=0", o_avg_valid); end
    idle(1);
    checks++; if (o_avg !== 6'd12)      begin errors++; $display("FAIL b2b_avg got=%0d exp=12", o_avg); end
    checks++; if (o_avg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%0b exp=1", o_avg_valid); end
    checks++; if (o_have_avg !== 1'b1)  begin errors++; $display("FAIL b2b_have got=%0b exp=1", o_have_avg); end
    checks++; if (o_min !== 6'd10)      begin errors++; $display("FAIL b2b_min got=%0d exp=10", o_min); end
    checks++; if (o_max !== 6'd13)      begin errors++; $display("FAIL b2b_max got=%0d exp=13", o_max); end
    checks++; if (o_alarm !== 1'b0)     begin errors++; $display("FAIL b2b_alarm got=%0b exp=0", o_alarm); end
    idle(1);
    checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_pulse got=%0b exp=0", o_avg_valid); end
    checks++; if (o_avg !== 6'd12)      begin errors++; $display("FAIL b2b_avg_hold got=%0d exp=12", o_avg); end
  endtask

  task automatic test_alarm();
    block4(63, 63, 63, 63);
    checks++; if (o_avg !== 6'd63)  begin errors++; $display("FAIL alm_avg63 got=%0d exp=63", o_avg); end
    checks++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alm_set got=%0b exp=1", o_alarm); end
    checks++; if (o_max !== 6'd63)  begin errors++; $display("FAIL alm_max got=%0d exp=63", o_max); end
    block4(35, 35, 35, 35);
    checks++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alm_hold got=%0b exp=1", o_alarm); end
    block4(29, 29, 29, 29);
    checks++; if (o_alarm !== 1'b0) begin errors++; $display("FAIL alm_clear got=%0b exp=0", o_alarm); end
    block4(40, 40, 40, 40);
    checks++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alm_set_eq_hi got=%0b exp=1", o_alarm); end
    block4(30, 30, 30, 30);
    checks++; if (o_alarm !== 1'b0) begin errors++; $display("FAIL alm_clr_eq_lo got=%0b exp=0", o_alarm); end
    block4(0, 0, 1, 1);
    checks++; if (o_avg !== 6'd1)   begin errors++; $display("FAIL rnd_half_up got=%0d exp=1", o_avg); end
    block4(1, 2, 2, 2);
    checks++; if (o_avg !== 6'd2)   begin errors++; $display("FAIL rnd_up got=%0d exp=2", o_avg); end
    i_thr_hi = 20; i_thr_lo = 50;
    block4(30, 30, 30, 30);
    checks++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alm_priority got=%0b exp=1", o_alarm); end
    i_thr_hi = 60; i_thr_lo = 50;
    idle(2);
    checks++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alm_thr_deferred got=%0b exp=1", o_alarm); end
    block4(30, 30, 30, 30);
    checks++; if (o_alarm !== 1'b0) begin errors++; $display("FAIL alm_thr_applied got=%0b exp=0", o_alarm); end
    i_thr_hi = 40; i_thr_lo = 30;
    block4(50, 50, 50, 50);
    checks++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alm_reset_setup got=%0b exp=1", o_alarm); end
  endtask

  task automatic test_reset_mid_block();
    send(50); idle(5);
    send(60); idle(2);
    #2 reset = 1'b1;
    #1;
    checks++; if (o_avg !== 6'd0)      begin errors++; $display("FAIL mid_rst_avg got=%0d exp=0", o_avg); end
    checks++; if (o_have_avg !== 1'b0) begin errors++; $display("FAIL mid_rst_have got=%0b exp=0", o_have_avg); end
    checks++; if (o_alarm !== 1'b0)    begin errors++; $display("FAIL mid_rst_alarm got=%0b exp=0", o_alarm); end
    checks++; if (o_min !== 6'd63)     begin errors++; $display("FAIL mid_rst_min got=%0d exp=63", o_min); end
    checks++; if (o_max !== 6'd0)      begin errors++; $display("FAIL mid_rst_max got=%0d exp=0", o_max); end
    send(7);
    idle(1);
    reset = 1'b0;
    checks++; if (o_max !== 6'd0)      begin errors++; $display("FAIL strobe_in_rst got=%0d exp=0", o_max); end
    send(8); send(8); send(8);
    idle(1);
    checks++; if (o_have_avg !== 1'b0) begin errors++; $display("FAIL mid_no_residue got=%0b exp=0", o_have_avg); end
    send(9);
    idle(1);
    checks++; if (o_avg !== 6'd8)      begin errors++; $display("FAIL mid_avg got=%0d exp=8", o_avg); end
    checks++; if (o_avg_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got=%0b exp=1", o_avg_valid); end
    checks++; if (o_min !== 6'd8)      begin errors++; $display("FAIL mid_min got=%0d exp=8", o_min); end
    checks++; if (o_max !== 6'd9)      begin errors++; $display("FAIL mid_max got=%0d exp=9", o_max); end
  endtask

  task automatic test_clear_minmax();
    pulse_reset();
    send(5); send(50);
    send(20);
    i_clear_minmax = 1'b1;
    idle(1);
    checks++; if (o_min !== 6'd20) begin errors++; $display("FAIL clr_same_min got=%0d exp=20", o_min); end
    checks++; if (o_max !== 6'd20) begin errors++; $display("FAIL clr_same_max got=%0d exp=20", o_max); end
    @(negedge clk);
    i_clear_minmax = 1'b1;
    idle(1);
    checks++; if (o_min !== 6'd63) begin errors++; $display("FAIL clr_min got=%0d exp=63", o_min); end
    checks++; if (o_max !== 6'd0)  begin errors++; $display("FAIL clr_max got=%0d exp=0", o_max); end
  endtask

  task automatic test_spike();
    pulse_reset();
`ifdef TEMP_FILTER_SPIKE_REJECT_EN
    send(20); send(40); send(41);
    idle(1);
    checks++; if (o_reject_cnt !== 4'd2) begin errors++; $display("FAIL spk_rej2 got=%0d exp=2", o_reject_cnt); end
    checks++; if (o_max !== 6'd20)       begin errors++; $display("FAIL spk_max_pre got=%0d exp=20", o_max); end
    send(42);
    idle(1);
    checks++; if (o_reject_cnt !== 4'd2) begin errors++; $display("FAIL spk_force got=%0d exp=2", o_reject_cnt); end
    checks++; if (o_max !== 6'd42)       begin errors++; $display("FAIL spk_max got=%0d exp=42", o_max); end
    send(21);
    idle(1);
    checks++; if (o_reject_cnt !== 4'd3) begin errors++; $display("FAIL spk_rej3 got=%0d exp=3", o_reject_cnt); end
    checks++; if (o_min !== 6'd20)       begin errors++; $display("FAIL spk_min got=%0d exp=20", o_min); end
    checks++; if (o_have_avg !== 1'b0)   begin errors++; $display("FAIL spk_pending got=%0b exp=0", o_have_avg); end
`else
    send(20); send(40); send(41); send(42);
    idle(1);
    checks++; if (o_avg !== 6'd36)       begin errors++; $display("FAIL nospk_avg got=%0d exp=36", o_avg); end
    checks++; if (o_avg_valid !== 1'b1)  begin errors++; $display("FAIL nospk_valid got=%0b exp=1", o_avg_valid); end
    checks++; if (o_max !== 6'd42)       begin errors++; $display("FAIL nospk_max got=%0d exp=42", o_max); end
    send(21);
    idle(1);
    checks++; if (o_reject_cnt !== 4'd0) begin errors++; $display("FAIL nospk_rej got=%0d exp=0", o_reject_cnt); end
    checks++; if (o_min !== 6'd20)       begin errors++; $display("FAIL nospk_min got=%0d exp=20", o_min); end
`endif
  endtask

  initial begin
    reset           = 1'b1;
    bus.i_res_valid = 1'b0;
    bus.i_res       = '0;
    i_clear_minmax  = 1'b0;
    i_thr_hi        = 6'd40;
    i_thr_lo        = 6'd30;
    test_reset();
    test_back_to_back();
    test_alarm();
    test_reset_mid_block();
    test_clear_minmax();
    test_spike();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temp_result_filter.md
Name: temp_result_filter

Overview:
Downstream consumer of the temperature sensor's raw conversion result. It accepts one raw N_RES-bit code per valid strobe and forms a rounded block average over 2**LOG2_AVG samples. It also tracks min/max and drives a hysteresis over-temperature alarm. Its outputs feed the calibration LUT / bin2dec / seg7 display path and the debug mux.

Parameters:
N_RES, 6, width of raw result code (matches VDAC resolution)
LOG2_AVG, 2, log2 of samples per average; legal range 1..4
MAX_STEP, 8, max accepted step between consecutive samples (used only by optional feature)

Ports:
clk  input  1  system clock (same 10 kHz clock as the sensor state machine)
reset  input  1  asynchronous, active-high reset
i_res_valid  input  1  one-cycle strobe: i_res holds a new conversion result
i_res  input  N_RES  raw conversion result
i_clear_minmax  input  1  synchronous clear of min/max trackers
i_thr_hi  input  N_RES  alarm set threshold
i_thr_lo  input  N_RES  alarm clear threshold
o_avg  output  N_RES  latest rounded average
o_avg_valid  output  1  one-cycle pulse when o_avg updates
o_have_avg  output  1  high once at least one average has been produced since reset
o_min  output  N_RES  minimum accepted sample
o_max  output  N_RES  maximum accepted sample
o_alarm  output  1  hysteresis over-temperature flag
o_reject_cnt  output  4  saturating count of rejected samples

Behaviour:
- Reset (async, any time, including mid-block): accumulator=0, sample counter=0, o_avg=0, o_avg_valid=0, o_have_avg=0, o_min=all ones, o_max=0, o_alarm=0, o_reject_cnt=0, FSM=FILL.
- FSM states:
  - FILL: no average produced yet. Goes to RUN when the first block completes.
  - RUN: steady state. Leaves only on reset.
- Accumulation:
  - Accumulator width is N_RES+LOG2_AVG+1.
  - A sample is accepted on a rising clk edge where i_res_valid=1 (and it is not rejected, see Optional Feature).
  - Each accepted sample adds to the accumulator and increments the counter.
- Block completion, on the 2**LOG2_AVG-th accepted sample:
  - o_avg <= (acc + sample + 2**(LOG2_AVG-1)) >> LOG2_AVG. The result is at most 2**N_RES-1, so no saturation is needed.
  - o_avg_valid=1 for exactly the following cycle; o_have_avg=1 from then on.
  - Accumulator and counter cleared in the same edge.
- Back-to-back strobes on every cycle are supported with no lost sample.
- Latency: o_avg and o_avg_valid update 1 clk after the completing strobe edge.
- Min/max:
  - Every accepted sample updates o_min=min(o_min,s) and o_max=max(o_max,s), registered at the same edge.
  - i_clear_minmax restores o_min=all ones, o_max=0.
  - Clear and accepted sample in the same cycle: o_min=o_max=s.
- Alarm, evaluated only on the cycle o_avg is updated, using the new average:
  - new avg >= i_thr_hi: set.
  - else new avg <= i_thr_lo: clear.
  - else hold.
  - If i_thr_lo >= i_thr_hi, set has priority.
  - Thresholds may change at any time; a change takes effect at the next average.
- Strobe while reset is asserted: ignored.
- Counter wrap: the counter is exactly LOG2_AVG bits and wraps to 0 at completion.

Optional Feature:
Macro TEMP_FILTER_SPIKE_REJECT_EN.
- Defined:
  - A register holds the last accepted sample; the first sample after reset is always accepted.
  - A sample with |s - last| > MAX_STEP is rejected: not accumulated, no min/max update, o_reject_cnt increments (saturates at 15).
  - The 3rd consecutive rejected-class sample is force-accepted and becomes the new reference; this follows genuine temperature steps.
  - Any accepted sample zeroes the consecutive-reject count.
- Not defined: every strobed sample is accepted, o_reject_cnt is tied to 0, and MAX_STEP is unused.

Test Plan:
1. Reset, then strobes 10,11,12,13 every cycle -> 1 clk after the 4th edge: o_avg=12 (46+2=48>>2); o_avg_valid high 1 cycle; o_have_avg=1; o_min=10; o_max=13.
2. Strobes 63,63,63,63 -> o_avg=63 (no overflow); with i_thr_hi=40, i_thr_lo=30: o_alarm=1. Then blocks averaging 35 -> alarm holds 1; then 29 -> o_alarm=0.
3. Strobes spaced 5 idle cycles apart, with reset asserted after the 2nd -> all outputs at reset values. The next 4 strobes yield their own average with no residue from before.
4. Sample 20 with i_clear_minmax in the same cycle after prior min 5 / max 50 -> o_min=o_max=20.
5. (Macro defined) Samples 20, 40, 41, 42, 21 -> 40 and 41 rejected (o_reject_cnt=2); 42 force-accepted; 21 rejected (|21-42|>8); first average pending.
6. (Macro undefined) same sequence as test 5 -> all accepted; o_reject_cnt=0; o_avg=(20+40+41+42+2)>>2=36 after the 4th sample.
